// File: rtl/osc_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_mon_pkg
// Brief    : Shared types and constants for the oscillator frequency monitor.
// Revision : 1.0 - initial release
// ============================================================================
package osc_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int c_GATE_CYCLES_DFLT = 50000;
    localparam int c_GATE_W           = $clog2(c_GATE_CYCLES_DFLT);

    // Limits for a 1 MHz source over a 1 ms gate
    localparam int c_MIN_CNT_DFLT = 990;
    localparam int c_MAX_CNT_DFLT = 1010;

    function automatic int gate_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : osc_mon_if
// Brief    : Control, limit and result bundle of the frequency monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface osc_mon_if #(
    parameter int CNT_W = 16
) ();

    logic             MON_IN;
    logic             START;
    logic             ABORT;
    logic             CONTINUOUS;
    logic [CNT_W-1:0] MIN_CNT;
    logic [CNT_W-1:0] MAX_CNT;
    logic [CNT_W-1:0] COUNT;
    logic             VALID;
    logic             BUSY;
    logic             TOO_LOW;
    logic             TOO_HIGH;
    logic             SAT;
    logic             FAULT;

    modport master (
        output MON_IN, START, ABORT, CONTINUOUS, MIN_CNT, MAX_CNT,
        input  COUNT, VALID, BUSY, TOO_LOW, TOO_HIGH, SAT, FAULT
    );

    modport slave (
        input  MON_IN, START, ABORT, CONTINUOUS, MIN_CNT, MAX_CNT,
        output COUNT, VALID, BUSY, TOO_LOW, TOO_HIGH, SAT, FAULT
    );

endinterface
`default_nettype wire

// File: rtl/osc_mon_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : osc_mon_edge_sync
// Brief    : Two-flop synchronizer plus delay flop; one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module osc_mon_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : osc_freq_monitor
// Brief    : Counts MON_IN rising edges over a fixed CLK gate window and
//            range-checks the result against programmable limits.
// Revision : 1.0 - initial release
// ============================================================================
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int GATE_CYCLES = c_GATE_CYCLES_DFLT,
    parameter int CNT_W       = 16
) (
    input  logic     CLK,
    input  logic     RESET,
    osc_mon_if.slave bus
);

    localparam int              c_GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [c_GW-1:0] c_GATE_LAST = c_GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic             w_report;
    logic             w_rise;
    logic             w_too_low;
    logic             w_too_high;
    logic [c_GW-1:0]  r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_busy;
    logic             r_too_low;
    logic             r_too_high;
    logic             r_sat_out;
    logic             r_fault;

    osc_mon_edge_sync u_edge_sync (
        .clk     (CLK),
        .rst     (RESET),
        .i_async (bus.MON_IN),
        .o_rise  (w_rise)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // ABORT overrides every transition, including the REPORT commit
    always_comb begin
        w_next   = r_state;
        w_report = 1'b0;
        if (bus.ABORT) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (bus.START) w_next = ST_GATE;
                ST_GATE:   if (r_gate_cnt == c_GATE_LAST) w_next = ST_REPORT;
                ST_REPORT: begin
                    w_report = 1'b1;
                    w_next   = bus.CONTINUOUS ? ST_GATE : ST_IDLE;
                end
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // Counters hold their final value through REPORT and clear outside GATE,
    // so an edge seen in the REPORT cycle is never counted.
    always_ff @(posedge CLK) begin
        if (RESET || (r_state != ST_GATE)) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_gate_cnt <= r_gate_cnt + c_GW'(1);
            if (w_rise) begin
                if (r_edge_cnt == c_CNT_MAX) r_sat      <= 1'b1;
                else                         r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
        end
    end

    assign w_too_low  = (r_edge_cnt < bus.MIN_CNT);
    assign w_too_high = (r_edge_cnt > bus.MAX_CNT) || r_sat;

    // VALID is registered alongside COUNT so it marks the cycle the new result appears
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_too_low  <= 1'b0;
            r_too_high <= 1'b0;
            r_sat_out  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_valid <= w_report;
            r_busy  <= (w_next != ST_IDLE);
            if (w_report) begin
                r_count    <= r_edge_cnt;
                r_sat_out  <= r_sat;
                r_too_low  <= w_too_low;
                r_too_high <= w_too_high;
                r_fault    <= w_too_low | w_too_high;
            end
        end
    end

    assign bus.COUNT    = r_count;
    assign bus.VALID    = r_valid;
    assign bus.BUSY     = r_busy;
    assign bus.TOO_LOW  = r_too_low;
    assign bus.TOO_HIGH = r_too_high;
    assign bus.SAT      = r_sat_out;
    assign bus.FAULT    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_freq_monitor
// Brief    : Self-checking bench for osc_freq_monitor with an edge-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_freq_monitor;

    localparam int G      = 1000;
    localparam int CW     = 16;
    localparam int CW2    = 4;
    localparam int MAXCYC = 60000;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int period     = 50;
    int phase      = 0;
    int last_count = 0;
    bit hist [0:MAXCYC];

    osc_mon_if #(.CNT_W(CW))  bus  ();
    osc_mon_if #(.CNT_W(CW2)) bus2 ();

    osc_freq_monitor #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    osc_freq_monitor #(.GATE_CYCLES(G), .CNT_W(CW2)) dut2 (
        .CLK(CLK), .RESET(RESET), .bus(bus2)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to the next falling edge; MON_IN is updated here and recorded
    // as the value the DUT will sample on the following rising edge.
    task automatic tick();
        bit m;
        @(negedge CLK);
        cyc++;
        m = (((cyc + phase) % period) < (period / 2));
        bus.MON_IN  = m;
        bus2.MON_IN = m;
        if (cyc <= MAXCYC) hist[cyc] = m;
    endtask

    // Rises of the sampled input, seen two clocks late through the
    // synchronizer, that fall inside the G-cycle window starting at edge s.
    function automatic int model_edges(input int s);
        int n = 0;
        for (int k = s; k < s + G; k++)
            if (hist[k-1] && !hist[k-2]) n++;
        return n;
    endfunction

    task automatic pulse_start(output int s);
        bus.START = 1'b1;
        s = cyc;
        tick();
        bus.START = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (bus.VALID === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic measure(input int mn, input int mx, output int s, output int at, output bit ok);
        bus.MIN_CNT = CW'(mn);
        bus.MAX_CNT = CW'(mx);
        pulse_start(s);
        wait_valid(G + 20, at, ok);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        checks++; if (bus.COUNT !== 16'd0)  begin failures++; $display("FAIL reset_count: got %0d want 0", bus.COUNT); end
        checks++; if (bus.VALID !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b want 0", bus.VALID); end
        checks++; if (bus.BUSY !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.TOO_LOW !== 1'b0) begin failures++; $display("FAIL reset_too_low: got %b want 0", bus.TOO_LOW); end
        checks++; if (bus.TOO_HIGH !== 1'b0) begin failures++; $display("FAIL reset_too_high: got %b want 0", bus.TOO_HIGH); end
        checks++; if (bus.SAT !== 1'b0)     begin failures++; $display("FAIL reset_sat: got %b want 0", bus.SAT); end
        checks++; if (bus.FAULT !== 1'b0)   begin failures++; $display("FAIL reset_fault: got %b want 0", bus.FAULT); end
        RESET = 1'b0;
        repeat (5) tick();
        checks++; if (bus.BUSY !== 1'b0)    begin failures++; $display("FAIL idle_busy: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_basic();
        int s, at, n;
        bit ok;
        period = 50;
        phase  = $urandom_range(0, 49);
        bus.MIN_CNT = 16'd18;
        bus.MAX_CNT = 16'd22;
        repeat (3) tick();
        pulse_start(s);
        checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b want 1", bus.BUSY); end
        wait_valid(G + 20, at, ok);
        checks++; if (!ok || at != s + G + 2) begin failures++; $display("FAIL basic_latency: got %0d want %0d", at - s, G + 2); end
        n = model_edges(s);
        checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL basic_count_model: got %0d want %0d", bus.COUNT, n); end
        checks++; if (bus.COUNT !== 16'd20) begin failures++; $display("FAIL basic_count: got %0d want 20", bus.COUNT); end
        checks++; if ({bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT} !== 4'b0000) begin
            failures++; $display("FAIL basic_flags: got %b want 0000", {bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT}); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_done: got %b want 0", bus.BUSY); end
        tick();
        checks++; if (bus.VALID !== 1'b0) begin failures++; $display("FAIL valid_one_cycle: got %b want 0", bus.VALID); end
        last_count = n;
    endtask

    task automatic test_limits();
        int s, at, n;
        bit ok;
        int mins [4] = '{21, 18, 25, 20};
        int maxs [4] = '{22, 19, 10, 20};
        logic [3:0] exp_f;
        period = 50;
        for (int i = 0; i < 4; i++) begin
            measure(mins[i], maxs[i], s, at, ok);
            n = model_edges(s);
            exp_f[3] = (n < mins[i]);
            exp_f[2] = (n > maxs[i]);
            exp_f[1] = 1'b0;
            exp_f[0] = exp_f[3] | exp_f[2];
            checks++; if (!ok || at != s + G + 2) begin failures++; $display("FAIL limits_latency[%0d]: got %0d want %0d", i, at - s, G + 2); end
            checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL limits_count[%0d]: got %0d want %0d", i, bus.COUNT, n); end
            checks++; if ({bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT} !== exp_f) begin
                failures++; $display("FAIL limits_flags[%0d]: got %b want %b", i, {bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT}, exp_f); end
            last_count = n;
        end
    endtask

    task automatic test_random();
        int s, at, n, est, mn, mx;
        bit ok;
        logic [3:0] exp_f;
        for (int i = 0; i < 5; i++) begin
            period = $urandom_range(6, 90);
            phase  = $urandom_range(0, period - 1);
            est = G / period;
            mn  = est + $urandom_range(0, 6) - 3;
            mx  = est + $urandom_range(0, 6) - 3;
            measure(mn, mx, s, at, ok);
            n = model_edges(s);
            exp_f[3] = (n < mn);
            exp_f[2] = (n > mx);
            exp_f[1] = 1'b0;
            exp_f[0] = exp_f[3] | exp_f[2];
            checks++; if (!ok || at != s + G + 2) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, at - s, G + 2); end
            checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL rand_count[%0d]: got %0d want %0d (period %0d)", i, bus.COUNT, n, period); end
            checks++; if ({bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT} !== exp_f) begin
                failures++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT}, exp_f); end
            last_count = n;
        end
    endtask

    task automatic test_saturation();
        int s, n, at;
        bit ok, sat_exp;
        period = 8;
        phase  = $urandom_range(0, 7);
        bus2.MIN_CNT = 4'd0;
        bus2.MAX_CNT = 4'hF;
        repeat (3) tick();
        bus2.START = 1'b1;
        s = cyc;
        tick();
        bus2.START = 1'b0;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < G + 20 && !ok; i++) begin
            tick();
            if (bus2.VALID === 1'b1) begin ok = 1'b1; at = cyc; end
        end
        n = model_edges(s);
        sat_exp = (n > 15);
        checks++; if (!ok || at != s + G + 2) begin failures++; $display("FAIL sat_latency: got %0d want %0d", at - s, G + 2); end
        checks++; if (bus2.COUNT !== 4'((n > 15) ? 15 : n)) begin failures++; $display("FAIL sat_count: got %0d want 15 (edges %0d)", bus2.COUNT, n); end
        checks++; if ({bus2.TOO_LOW, bus2.TOO_HIGH, bus2.SAT, bus2.FAULT} !== {1'b0, sat_exp, sat_exp, sat_exp}) begin
            failures++; $display("FAIL sat_flags: got %b want %b", {bus2.TOO_LOW, bus2.TOO_HIGH, bus2.SAT, bus2.FAULT}, {1'b0, sat_exp, sat_exp, sat_exp}); end
    endtask

    task automatic test_continuous();
        int s, sw, at, n, vcount;
        bit ok;
        period = 50;
        bus.MIN_CNT = 16'd18;
        bus.MAX_CNT = 16'd22;
        bus.CONTINUOUS = 1'b1;
        pulse_start(s);
        sw = s;
        for (int w = 0; w < 4; w++) begin
            wait_valid(G + 20, at, ok);
            checks++; if (!ok || at != sw + G + 2) begin failures++; $display("FAIL cont_valid_time[%0d]: got %0d want %0d", w, at - s, sw - s + G + 2); end
            n = model_edges(sw);
            checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL cont_count[%0d]: got %0d want %0d", w, bus.COUNT, n); end
            checks++; if (bus.BUSY !== (w < 3)) begin failures++; $display("FAIL cont_busy[%0d]: got %b want %b", w, bus.BUSY, (w < 3)); end
            if (w == 2) bus.CONTINUOUS = 1'b0;
            sw = sw + G + 1;
            last_count = n;
        end
        vcount = 0;
        repeat (G + 20) begin
            tick();
            if (bus.VALID === 1'b1) vcount++;
        end
        checks++; if (vcount != 0) begin failures++; $display("FAIL cont_stopped: got %0d extra VALIDs want 0", vcount); end
    endtask

    task automatic test_abort();
        int s, vcount;
        period = 50;
        pulse_start(s);
        while (cyc < s + 500) tick();
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL abort_gate_busy: got %b want 0", bus.BUSY); end
        vcount = 0;
        repeat (G + 20) begin
            tick();
            if (bus.VALID === 1'b1) vcount++;
        end
        checks++; if (vcount != 0) begin failures++; $display("FAIL abort_gate_valid: got %0d VALIDs want 0", vcount); end
        checks++; if (bus.COUNT !== CW'(last_count)) begin failures++; $display("FAIL abort_gate_count: got %0d want %0d", bus.COUNT, last_count); end
        // Abort landing on the REPORT cycle must suppress the result update
        period = 40;
        pulse_start(s);
        while (cyc < s + G + 1) tick();
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        checks++; if (bus.VALID !== 1'b0) begin failures++; $display("FAIL abort_report_valid: got %b want 0", bus.VALID); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL abort_report_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.COUNT !== CW'(last_count)) begin failures++; $display("FAIL abort_report_count: got %0d want %0d", bus.COUNT, last_count); end
    endtask

    task automatic test_start_while_busy();
        int s, n;
        period = 50;
        pulse_start(s);
        while (cyc < s + 100) tick();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        while (cyc < s + G + 1) tick();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        n = model_edges(s);
        checks++; if (bus.VALID !== 1'b1) begin failures++; $display("FAIL busy_start_valid: got %b want 1 at offset %0d", bus.VALID, G + 2); end
        checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL busy_start_count: got %0d want %0d", bus.COUNT, n); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL busy_start_idle: got %b want 0", bus.BUSY); end
        last_count = n;
    endtask

    task automatic test_reset_mid_gate();
        int s, at, n;
        bit ok;
        period = 40;
        measure(30, 40, s, at, ok);
        n = model_edges(s);
        checks++; if ({bus.TOO_LOW, bus.FAULT} !== {(n < 30), (n < 30) | (n > 40)}) begin
            failures++; $display("FAIL pre_reset_flags: got %b want %b", {bus.TOO_LOW, bus.FAULT}, {(n < 30), (n < 30) | (n > 40)}); end
        pulse_start(s);
        while (cyc < s + 300) tick();
        RESET = 1'b1;
        tick();
        checks++; if ({bus.COUNT, bus.VALID, bus.BUSY, bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT} !== '0) begin
            failures++; $display("FAIL mid_reset_outputs: count=%0d valid=%b busy=%b lo=%b hi=%b sat=%b fault=%b want all 0",
                bus.COUNT, bus.VALID, bus.BUSY, bus.TOO_LOW, bus.TOO_HIGH, bus.SAT, bus.FAULT); end
        RESET = 1'b0;
        repeat (5) tick();
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got %b want 0", bus.BUSY); end
        period = 50;
        repeat (3) tick();
        measure(18, 22, s, at, ok);
        n = model_edges(s);
        checks++; if (!ok || at != s + G + 2) begin failures++; $display("FAIL post_reset_latency: got %0d want %0d", at - s, G + 2); end
        checks++; if (bus.COUNT !== CW'(n)) begin failures++; $display("FAIL post_reset_count: got %0d want %0d", bus.COUNT, n); end
    endtask

    initial begin
        bus.MON_IN      = 1'b0;
        bus.START       = 1'b0;
        bus.ABORT       = 1'b0;
        bus.CONTINUOUS  = 1'b0;
        bus.MIN_CNT     = 16'd18;
        bus.MAX_CNT     = 16'd22;
        bus2.MON_IN     = 1'b0;
        bus2.START      = 1'b0;
        bus2.ABORT      = 1'b0;
        bus2.CONTINUOUS = 1'b0;
        bus2.MIN_CNT    = 4'd0;
        bus2.MAX_CNT    = 4'hF;

        test_reset();
        test_basic();
        test_limits();
        test_random();
        test_saturation();
        test_continuous();
        test_abort();
        test_start_while_busy();
        test_reset_mid_gate();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osc_freq_monitor.md
# osc_freq_monitor

Measures the frequency of a slow, asynchronous clock or toggling signal by counting its rising edges over a fixed gate window of the local clock. Range-checks the result against programmable limits. It sits downstream of the on-chip oscillator block, clocked from the RCOSC 50 MHz output. Its job is to verify the crystal, 1 MHz RC, or camera XCLK/PCLK-derived signals during SCCB bring-up, and to report a count plus a fault flag to the APB wrapper.

## Interface
Parameters:
- GATE_CYCLES, 50000, gate window length in CLK cycles (1 ms at 50 MHz); legal range 2..2^24-1
- CNT_W, 16, width of edge counter and limits

Ports:
- CLK  in  1  single clock (RCOSC 50 MHz domain)
- RESET  in  1  reset, synchronous, active-high
- MON_IN  in  1  asynchronous monitored signal; must be below CLK/4
- START  in  1  one-cycle request to begin measurement; ignored while BUSY
- ABORT  in  1  stop measurement, return to IDLE, no result
- CONTINUOUS  in  1  when 1, windows repeat back-to-back until ABORT; sampled in REPORT
- MIN_CNT  in  CNT_W  lower limit, inclusive; sampled at REPORT
- MAX_CNT  in  CNT_W  upper limit, inclusive; sampled at REPORT
- COUNT  out  CNT_W  last completed edge count; held until next REPORT
- VALID  out  1  one-cycle pulse when COUNT/flags update
- BUSY  out  1  high in GATE and REPORT
- TOO_LOW  out  1  COUNT < MIN_CNT
- TOO_HIGH  out  1  COUNT > MAX_CNT or SAT
- SAT  out  1  counter saturated during window
- FAULT  out  1  TOO_LOW | TOO_HIGH; held with COUNT

## Operation
- MON_IN passes through a 2-flop synchronizer and a delay flop. A rising edge is s2 & ~s3.
- All three sync flops reset to 0. Edge pulses are only counted in GATE, so reset-release artefacts are harmless unless START comes within 3 cycles of reset release. The bench avoids this; no extra logic is required.
- FSM states: IDLE, GATE, REPORT.
  - IDLE: START=1 (and ABORT=0) → GATE. Gate counter loads 0, edge counter loads 0.
  - GATE: gate counter increments each cycle. Edge counter increments on each edge and saturates at all-ones, setting an internal sat bit. On gate counter == GATE_CYCLES-1 → REPORT.
  - REPORT: register COUNT, SAT, TOO_LOW, TOO_HIGH, FAULT, and pulse VALID. Next state is GATE (counters cleared) if CONTINUOUS=1, else IDLE.
- ABORT in any state → IDLE next cycle. COUNT and flags are unchanged and VALID is not asserted. ABORT takes priority over START and over the REPORT transition. In REPORT with ABORT, no update happens.
- Comparison: unsigned, CNT_W bits. MIN_CNT > MAX_CNT is legal; both flags may assert.
- START while BUSY: ignored, no queuing.

## Timing
- Reset values: COUNT=0, VALID=0, BUSY=0, TOO_LOW=0, TOO_HIGH=0, SAT=0, FAULT=0; state IDLE.
- START asserted in cycle t → BUSY=1 from t+1. GATE occupies t+1..t+GATE_CYCLES. REPORT and the VALID pulse occur in cycle t+GATE_CYCLES+1, with outputs visible from t+GATE_CYCLES+2.
- An edge detected in the last GATE cycle counts. An edge detected in the REPORT cycle is dropped, leaving a one-cycle dead time between continuous windows.
- Synchronizer latency is 2 cycles. Edges within 2 cycles before GATE entry may be counted in the window.
- Continuous period is GATE_CYCLES+1 cycles per VALID.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Package osc_mon_pkg holds:
  - the state enum (IDLE, GATE, REPORT);
  - a localparam for gate counter width, $clog2(GATE_CYCLES);
  - default limit constants for 1 MHz at a 1 ms gate (MIN 990, MAX 1010).
- Sub-module osc_mon_edge_sync: 2-flop synchronizer plus delay flop, emits a one-cycle rise pulse, synchronous reset.
- The top holds the FSM, gate counter, saturating edge counter, and result registers.

## Test plan
- GATE_CYCLES=1000. MON_IN period 50 CLK (25 high/25 low), phased so 20 rises land in GATE. MIN=18, MAX=22. Pulse START → VALID at START+1001, COUNT=20, FAULT=0.
- Same stimulus with MIN=21 → TOO_LOW=1, FAULT=1. With MAX=19 → TOO_HIGH=1.
- CNT_W=4, MON_IN period 8, GATE_CYCLES=1000 → COUNT=15, SAT=1, TOO_HIGH=1.
- CONTINUOUS=1 for 3 windows → VALID every 1001 cycles, each COUNT=20. Then CONTINUOUS=0 → IDLE after the next REPORT, BUSY=0.
- ABORT at GATE cycle 500 → IDLE next cycle, no VALID, COUNT retains prior value. START pulsed while BUSY → no effect on timing.
- RESET asserted mid-GATE → next cycle all outputs 0 and state IDLE. A fresh START then measures normally.
